// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for N_REQ requesters with a hold limit.
//
// One requester owns the grant until it drops its request. While others are
// waiting, the owner is forced off after MAX_HOLD grant cycles
// (MAX_HOLD = 0 disables this). Each handover passes through exactly one
// IDLE cycle. The requester that was just released becomes the lowest
// priority in the next arbitration.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-low reset
//   req          - level-sensitive request vector, bit i = requester i
//   granted_req  - one-hot grant, all zero when idle
//   grant_valid  - any grant active
//   grant_id     - binary index of the current grant, 0 when idle
//   preempt      - pulse in the IDLE cycle that follows a forced release
//
// All outputs decode from flops only; there is no combinational path from
// req to any output.
module rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] granted_req,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             preempt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Last value hold_cnt may reach. With MAX_HOLD = 0 this is 0, so the
    // counter never moves.
    localparam logic [7:0]      HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0] PTR_LAST  = ID_W'(N_REQ - 1);

    logic [0:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [7:0]       hold_cnt;
    logic             pre_q;

    logic [N_REQ-1:0] ptr_onehot;
    logic             others;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;

    assign ptr_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << ptr;
    assign others     = |(req & ~ptr_onehot);

    // Search ptr+1, ptr+2, ... with an explicit wrap at N_REQ-1. A modulo
    // is avoided because N_REQ need not be a power of two.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == PTR_LAST) ? '0 : cand + ID_W'(1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            ptr      <= PTR_LAST;
            hold_cnt <= '0;
            pre_q    <= 1'b0;
        end else begin
            pre_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ptr stays put in IDLE, so the last owner ranks lowest.
                    if (win_found) begin
                        state    <= S_GRANT;
                        ptr      <= win_id;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    if (!req[ptr]) begin
                        state <= S_IDLE;
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && others) begin
                        state <= S_IDLE;
                        pre_q <= 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        // The counter saturates, so a sole owner keeps the
                        // grant indefinitely. A late competitor then forces
                        // the release at the very next edge.
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign grant_valid = (state == S_GRANT);
    assign granted_req = grant_valid ? ptr_onehot : '0;
    assign grant_id    = grant_valid ? ptr : '0;
    assign preempt     = pre_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter for N requesters. It grants one requester at a time and holds the grant until that requester releases it. A configurable hold limit forces the holder off when other requesters are waiting, so no requester starves. It is the successor to the fixed 3-request arbiter and sits between the request sources and the shared resource in the statemachine core.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default 2: width of `grant_id`; must equal ceil(log2(`N_REQ`)).
- `MAX_HOLD`, default 8: maximum grant cycles while other requests are pending; 0 disables preemption; legal range 0..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input N_REQ: request vector; bit i is requester i; level-sensitive.
- `granted_req` output N_REQ: one-hot grant; all zero when idle; registered.
- `grant_valid` output 1: high when any bit of `granted_req` is high.
- `grant_id` output ID_W: binary index of the current grant; 0 when idle.
- `preempt` output 1: one-cycle pulse in the idle cycle that follows a forced release.

## Operation
- Moore machine with two states, IDLE and GRANT. All outputs decode from registers only, with no combinational path from `req`.
- Internal registers:
  - `state`.
  - `ptr` (ID_W): index of the last granted requester.
  - `hold_cnt` (8 bit).
  - `preempt` flop.
- Reset (`reset`==0 at an edge):
  - state=IDLE, ptr=N_REQ-1, hold_cnt=0.
  - `granted_req`=0, `grant_valid`=0, `grant_id`=0, `preempt`=0.
  - Reset overrides everything, including in the middle of a grant.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise select the winner: the first set bit of `req` found by searching indices ptr+1, ptr+2, … modulo N_REQ, wrapping past N_REQ-1 to 0.
  - Then go to GRANT, set ptr=winner and hold_cnt=0.
- GRANT, evaluated in priority order:
  - `req[ptr]`==0 → go to IDLE (voluntary release; `preempt` stays 0).
  - Otherwise, if MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, and (`req` with bit ptr masked)≠0 → go to IDLE and set `preempt`=1 for the next cycle.
  - Otherwise stay in GRANT; hold_cnt increments and saturates at MAX_HOLD-1. With MAX_HOLD=0, hold_cnt stays 0.
- Sole requester: no preemption, regardless of hold_cnt. If a competitor arrives after saturation, the release happens at the next edge.
- Every handover passes through exactly one IDLE cycle with `granted_req`=0. Two requesters are never granted in the same cycle.
- `preempt` is high only in the IDLE cycle that follows a forced release, and is 0 in every other cycle.
- ptr is unchanged in IDLE. The requester just released therefore has the lowest priority in the next arbitration.
- Requests that toggle during IDLE are sampled only at the arbitration edge. A grant is never issued to a requester whose `req` bit was low at that edge.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k → `granted_req` valid in the cycle after edge k. This is 1 cycle from request to grant.
- Release latency: `req[ptr]` sampled low at edge k → `granted_req`=0 in the cycle after edge k.
- Maximum continuous grant under contention is MAX_HOLD cycles, followed by 1 IDLE cycle.
- Worst-case wait for a requester: (N_REQ-1)×(MAX_HOLD+1)+1 cycles.
- With no contention, the steady state is one IDLE cycle between successive grants to the same requester after a release.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with `req`=4'b1111 → all outputs 0 throughout. Release reset with `req`=4'b1111 → the first cycle is IDLE, then `granted_req`=4'b0001 and `grant_id`=0.
- **Round-robin order:** N_REQ=4, MAX_HOLD=0. All requesters assert; each drops its `req` 2 cycles after being granted, then reasserts. Required grant sequence is 0,1,2,3,0, with one IDLE cycle between grants and `preempt` never high.
- **Preemption:** MAX_HOLD=4, `req`=4'b1111 held constant.
  - Cycles 1–4: `granted_req`=0001.
  - Cycle 5: IDLE with `preempt`=1.
  - Cycles 6–9: `granted_req`=0010.
  - Period is 5 cycles, continuing 2, 3, 0.
- **Sole requester:** MAX_HOLD=4, only `req[2]` high for 20 cycles → `granted_req`=0100 continuously and `preempt`=0. Raising `req[0]` at cycle 20 → release at the next edge, then `preempt`=1, then grant to 0.
- **Wrap-around:** with ptr=3 (after granting 3 and releasing), `req`=4'b0101 → grant goes to requester 0, not 2. Release 0 with 2 still requesting → grant goes to 2.
- **Reset mid-grant:** while `granted_req`=0010 with hold_cnt=2, pulse `reset`=0 for one edge → all outputs 0 in the next cycle. With `req`=1111, arbitration then restarts from index 0.
